// File: rtl/acl_rx_pkt_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acl_fifo_pkg
//  Description : Shared types and constants for the ACL ingress packet FIFO:
//                write-side FSM state encoding, invalid-mode selectors,
//                statistics counter width and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package acl_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } fifo_state_e;

    localparam int INV_MODE_ZERO = 0;
    localparam int INV_MODE_DROP = 1;
    localparam int STAT_W        = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acl_rx_pkt_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : acl_rx_pkt_fifo_if
//  Description : Write stream, read strobe and status bundle of the ACL
//                ingress packet FIFO. master = traffic source/sink driving the
//                FIFO, slave = the FIFO itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acl_rx_pkt_fifo_if #(
    parameter int DATA_W = 8
);
    import acl_fifo_pkg::*;

    logic [DATA_W-1:0] i_rxd_tdata;
    logic              i_rxd_tvalid;
    logic              i_rxd_tlast;
    logic              o_rxd_tready;
    logic              i_fifo_invalid;
    logic              i_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_last;
    logic              o_rd_data_valid;
    logic              o_pkt_avail;
    logic              o_drop;
    logic [STAT_W-1:0] o_pkt_cnt;
    logic [STAT_W-1:0] o_drop_cnt;

    modport master (
        output i_rxd_tdata, i_rxd_tvalid, i_rxd_tlast, i_fifo_invalid, i_rd_valid,
        input  o_rxd_tready, o_rd_data, o_rd_last, o_rd_data_valid,
               o_pkt_avail, o_drop, o_pkt_cnt, o_drop_cnt
    );

    modport slave (
        input  i_rxd_tdata, i_rxd_tvalid, i_rxd_tlast, i_fifo_invalid, i_rd_valid,
        output o_rxd_tready, o_rd_data, o_rd_last, o_rd_data_valid,
               o_pkt_avail, o_drop, o_pkt_cnt, o_drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/acl_rx_pkt_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : acl_fifo_ram
//  Description : Simple dual-port RAM, DEPTH x WIDTH. Synchronous write,
//                registered read (data valid one cycle after rd_en). The read
//                register only updates on rd_en so the output holds otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module acl_fifo_ram #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [WIDTH-1:0]  wr_data,
    input  wire logic              rd_en,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic      [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read register, cleared by reset so the read outputs start at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/acl_rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : acl_rx_pkt_fifo
//  Description : Packet-aware store-and-forward receive FIFO. Beats are
//                written behind a commit pointer; the read side only sees
//                complete packets. Invalid packets (INVALID_MODE=1) and
//                packets larger than the FIFO are discarded with an o_drop
//                pulse. INVALID_MODE=0 zeroes read data instead.
//                Optional macro ACL_FIFO_STATS_EN builds saturating
//                committed/dropped packet counters; otherwise they read 0.
//                DEPTH must be a power of two and at least 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module acl_rx_pkt_fifo
    import acl_fifo_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int INVALID_MODE = 1
) (
    input wire logic         clk,
    input wire logic         rst,
    acl_rx_pkt_fifo_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    fifo_state_e      r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_commit_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_drop;
    logic             r_rd_valid;
    logic             r_rd_zero;

    logic [PTR_W-1:0] w_committed;
    logic             w_full;
    logic             w_has_pkt;
    logic             w_oversize;
    logic             w_invalid_drop;
    logic             w_enter_drop;
    logic             w_tready;
    logic             w_accept;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_drop_evt;
    logic [DATA_W:0]  w_ram_q;

    // Pointer arithmetic on ADDR_W+1 bits so full and empty stay distinct.
    assign w_full      = (r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH);
    assign w_committed = r_commit_ptr - r_rd_ptr;
    assign w_has_pkt   = (w_committed != '0);

    // Full with nothing committed means the open packet can never fit.
    assign w_oversize     = w_full && !w_has_pkt;
    assign w_invalid_drop = (INVALID_MODE == INV_MODE_DROP) && bus.i_fifo_invalid;
    assign w_enter_drop   = (r_state != DROP) && (w_invalid_drop || w_oversize);

    // An oversize packet is resolved by dropping it, so the source is never
    // stalled by it: the beat is taken and discarded.
    assign w_tready = (r_state == DROP) || !w_full || w_oversize;
    assign w_accept = bus.i_rxd_tvalid && w_tready;
    assign w_wr_en  = w_accept && (r_state != DROP) && !w_enter_drop;
    assign w_rd_en  = bus.i_rd_valid && w_has_pkt;

    // A discarded packet is reported when its last beat is swallowed, either
    // in DROP or in the very cycle the drop is decided.
    assign w_drop_evt = w_accept && bus.i_rxd_tlast &&
                        ((r_state == DROP) || w_enter_drop);

    acl_fifo_ram #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .wr_data ({bus.i_rxd_tlast, bus.i_rxd_tdata}),
        .rd_en   (w_rd_en),
        .rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .rd_data (w_ram_q)
    );

    // Write-side FSM, pointers and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_drop <= w_drop_evt;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case (r_state)
                IDLE, PKT: begin
                    if (w_enter_drop) begin
                        // Rewind over the partial packet; a tlast beat in this
                        // cycle closes the discarded packet immediately.
                        r_wr_ptr <= r_commit_ptr;
                        if (w_accept && bus.i_rxd_tlast) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DROP;
                        end
                    end else if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (bus.i_rxd_tlast) begin
                            r_commit_ptr <= r_wr_ptr + 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_state <= PKT;
                        end
                    end
                end
                DROP: begin
                    if (w_accept && bus.i_rxd_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read-side qualifiers: valid strobe and legacy zero-out flag, the latter
    // captured with the data so o_rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_zero <= (INVALID_MODE == INV_MODE_ZERO) && bus.i_fifo_invalid;
            end
        end
    end

    assign bus.o_rxd_tready    = w_tready;
    assign bus.o_rd_data       = r_rd_zero ? '0 : w_ram_q[DATA_W-1:0];
    assign bus.o_rd_last       = w_ram_q[DATA_W];
    assign bus.o_rd_data_valid = r_rd_valid;
    assign bus.o_pkt_avail     = w_has_pkt;
    assign bus.o_drop          = r_drop;

`ifdef ACL_FIFO_STATS_EN
    logic              w_commit;
    logic [STAT_W-1:0] r_pkt_cnt;
    logic [STAT_W-1:0] r_drop_cnt;

    assign w_commit = w_wr_en && bus.i_rxd_tlast;

    // Saturating committed / dropped packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_commit) begin
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
            end
            if (w_drop_evt) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign bus.o_pkt_cnt  = r_pkt_cnt;
    assign bus.o_drop_cnt = r_drop_cnt;
`else
    assign bus.o_pkt_cnt  = '0;
    assign bus.o_drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acl_rx_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acl_rx_pkt_fifo
//  Description : Self-checking bench for acl_rx_pkt_fifo. Two instances:
//                dut_a (DEPTH=16, drop mode) and dut_b (DEPTH=4, zero mode).
//                Per-cycle vectors drive one instance; read data is checked
//                against a queue of expected beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acl_rx_pkt_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    acl_rx_pkt_fifo_if #(.DATA_W(8)) ifa ();
    acl_rx_pkt_fifo_if #(.DATA_W(8)) ifb ();

    acl_rx_pkt_fifo #(.DATA_W(8), .DEPTH(16), .INVALID_MODE(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    acl_rx_pkt_fifo #(.DATA_W(8), .DEPTH(4), .INVALID_MODE(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         sel;   // 0 = dut_a, 1 = dut_b
        bit         r;     // assert reset this cycle
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       inv;
        logic       rd;
        logic       rdy;   // expected tready before the edge
        logic       av;    // expected pkt_avail after the edge
        logic       drp;   // expected drop after the edge
        logic       push;  // this read must return a beat
        logic [7:0] ed;
        logic       el;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    vec_t       tv[$];
    exp_t       sb[$];
    logic [7:0] hold_d [2];
    logic       hold_l [2];

    function automatic vec_t mk(bit sel, bit r, logic v, logic [7:0] d, logic l,
                                logic inv, logic rd, logic rdy, logic av, logic drp,
                                logic push, logic [7:0] ed, logic el, string name);
        vec_t t;
        t.sel = sel; t.r = r; t.v = v; t.d = d; t.l = l; t.inv = inv; t.rd = rd;
        t.rdy = rdy; t.av = av; t.drp = drp; t.push = push; t.ed = ed; t.el = el;
        t.name = name;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_rdy(bit s);  return s ? ifb.o_rxd_tready    : ifa.o_rxd_tready;    endfunction
    function automatic logic get_av(bit s);   return s ? ifb.o_pkt_avail     : ifa.o_pkt_avail;     endfunction
    function automatic logic get_drp(bit s);  return s ? ifb.o_drop          : ifa.o_drop;          endfunction
    function automatic logic get_rdv(bit s);  return s ? ifb.o_rd_data_valid : ifa.o_rd_data_valid; endfunction
    function automatic logic get_last(bit s); return s ? ifb.o_rd_last       : ifa.o_rd_last;       endfunction
    function automatic logic [7:0] get_data(bit s); return s ? ifb.o_rd_data : ifa.o_rd_data;       endfunction

    task automatic idle_inputs();
        ifa.i_rxd_tvalid = 1'b0; ifa.i_rxd_tdata = 8'h00; ifa.i_rxd_tlast = 1'b0;
        ifa.i_fifo_invalid = 1'b0; ifa.i_rd_valid = 1'b0;
        ifb.i_rxd_tvalid = 1'b0; ifb.i_rxd_tdata = 8'h00; ifb.i_rxd_tlast = 1'b0;
        ifb.i_fifo_invalid = 1'b0; ifb.i_rd_valid = 1'b0;
    endtask

    task automatic apply(vec_t t);
        exp_t e;
        idle_inputs();
        rst_a = (t.sel == 1'b0) && t.r;
        rst_b = (t.sel == 1'b1) && t.r;
        if (t.sel) begin
            ifb.i_rxd_tvalid = t.v; ifb.i_rxd_tdata = t.d; ifb.i_rxd_tlast = t.l;
            ifb.i_fifo_invalid = t.inv; ifb.i_rd_valid = t.rd;
        end else begin
            ifa.i_rxd_tvalid = t.v; ifa.i_rxd_tdata = t.d; ifa.i_rxd_tlast = t.l;
            ifa.i_fifo_invalid = t.inv; ifa.i_rd_valid = t.rd;
        end
        if (t.push) sb.push_back('{d: t.ed, l: t.el});
        #1;
        if (!t.r) check({t.name, " tready"}, 32'(get_rdy(t.sel)), 32'(t.rdy));
        @(posedge clk);
        #1;
        if (t.r) begin
            hold_d[t.sel] = 8'h00;
            hold_l[t.sel] = 1'b0;
            check({t.name, " tready"}, 32'(get_rdy(t.sel)), 32'd1);
        end
        check({t.name, " pkt_avail"}, 32'(get_av(t.sel)), 32'(t.av));
        check({t.name, " drop"}, 32'(get_drp(t.sel)), 32'(t.drp));
        check({t.name, " rd_valid"}, 32'(get_rdv(t.sel)), 32'(t.push));
        if (get_rdv(t.sel)) begin
            if (sb.size() == 0) begin
                check({t.name, " unexpected read"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({t.name, " rd_data"}, 32'(get_data(t.sel)), 32'(e.d));
                check({t.name, " rd_last"}, 32'(get_last(t.sel)), 32'(e.l));
                hold_d[t.sel] = e.d;
                hold_l[t.sel] = e.l;
            end
        end else begin
            check({t.name, " rd_data hold"}, 32'(get_data(t.sel)), 32'(hold_d[t.sel]));
        end
    endtask

    initial begin
        int exp_pkt_a, exp_drop_a, exp_pkt_b;
        idle_inputs();
        hold_d[0] = 8'h00; hold_d[1] = 8'h00;
        hold_l[0] = 1'b0;  hold_l[1] = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state of both instances.
        check("rst_a tready",   32'(ifa.o_rxd_tready),    32'd1);
        check("rst_a avail",    32'(ifa.o_pkt_avail),     32'd0);
        check("rst_a rdv",      32'(ifa.o_rd_data_valid), 32'd0);
        check("rst_a data",     32'(ifa.o_rd_data),       32'd0);
        check("rst_a last",     32'(ifa.o_rd_last),       32'd0);
        check("rst_a drop",     32'(ifa.o_drop),          32'd0);
        check("rst_a pkt_cnt",  32'(ifa.o_pkt_cnt),       32'd0);
        check("rst_b tready",   32'(ifb.o_rxd_tready),    32'd1);
        check("rst_b avail",    32'(ifb.o_pkt_avail),     32'd0);
        check("rst_b drop_cnt", 32'(ifb.o_drop_cnt),      32'd0);

        // Single beat A5 then read.
        tv.push_back(mk(0,0,1,8'hA5,1,0,0, 1,1,0, 0,8'h00,0, "t1_wr"));
        tv.push_back(mk(0,0,0,8'h00,0,0,1, 1,0,0, 1,8'hA5,1, "t1_rd"));
        tv.push_back(mk(0,0,0,8'h00,0,0,0, 1,0,0, 0,8'h00,0, "t1_idle"));
        // 3-beat packet with read held high throughout.
        tv.push_back(mk(0,0,1,8'h11,0,0,1, 1,0,0, 0,8'h00,0, "t2_b1"));
        tv.push_back(mk(0,0,1,8'h22,0,0,1, 1,0,0, 0,8'h00,0, "t2_b2"));
        tv.push_back(mk(0,0,1,8'h33,1,0,1, 1,1,0, 0,8'h00,0, "t2_b3"));
        tv.push_back(mk(0,0,0,8'h00,0,0,1, 1,1,0, 1,8'h11,0, "t2_r1"));
        tv.push_back(mk(0,0,0,8'h00,0,0,1, 1,1,0, 1,8'h22,0, "t2_r2"));
        tv.push_back(mk(0,0,0,8'h00,0,0,1, 1,0,0, 1,8'h33,1, "t2_r3"));
        tv.push_back(mk(0,0,0,8'h00,0,0,1, 1,0,0, 0,8'h00,0, "t2_rempty"));
        // Invalid on beat 3 drops the packet; o_drop on the tlast beat.
        tv.push_back(mk(0,0,1,8'h01,0,0,0, 1,0,0, 0,8'h00,0, "t3_b1"));
        tv.push_back(mk(0,0,1,8'h02,0,0,0, 1,0,0, 0,8'h00,0, "t3_b2"));
        tv.push_back(mk(0,0,1,8'h03,0,1,0, 1,0,0, 0,8'h00,0, "t3_b3inv"));
        tv.push_back(mk(0,0,1,8'h04,1,0,0, 1,0,1, 0,8'h00,0, "t3_b4"));
        tv.push_back(mk(0,0,0,8'h00,0,0,0, 1,0,0, 0,8'h00,0, "t3_idle"));
        tv.push_back(mk(0,0,1,8'h5A,1,0,0, 1,1,0, 0,8'h00,0, "t3_next_wr"));
        tv.push_back(mk(0,0,0,8'h00,0,0,1, 1,0,0, 1,8'h5A,1, "t3_next_rd"));
        // DEPTH=4 oversize packet: 6 beats, never stalled, dropped on beat 6.
        tv.push_back(mk(1,0,1,8'hC1,0,0,0, 1,0,0, 0,8'h00,0, "ovf_b1"));
        tv.push_back(mk(1,0,1,8'hC2,0,0,0, 1,0,0, 0,8'h00,0, "ovf_b2"));
        tv.push_back(mk(1,0,1,8'hC3,0,0,0, 1,0,0, 0,8'h00,0, "ovf_b3"));
        tv.push_back(mk(1,0,1,8'hC4,0,0,0, 1,0,0, 0,8'h00,0, "ovf_b4"));
        tv.push_back(mk(1,0,1,8'hC5,0,0,0, 1,0,0, 0,8'h00,0, "ovf_b5"));
        tv.push_back(mk(1,0,1,8'hC6,1,0,0, 1,0,1, 0,8'h00,0, "ovf_b6"));
        tv.push_back(mk(1,0,0,8'h00,0,0,0, 1,0,0, 0,8'h00,0, "ovf_empty"));
        // Legacy zero-out on read.
        tv.push_back(mk(1,0,1,8'hFF,1,0,0, 1,1,0, 0,8'h00,0, "zero_wr"));
        tv.push_back(mk(1,0,0,8'h00,0,1,1, 1,0,0, 1,8'h00,1, "zero_rd"));
        // Fill DEPTH=4, then read+write across pointer wrap.
        tv.push_back(mk(1,1,0,8'h00,0,0,0, 1,0,0, 0,8'h00,0, "b_rst"));
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(1,0,1,8'(8'h10 + i),1,0,0, 1,1,0, 0,8'h00,0, "fill_wr"));
        tv.push_back(mk(1,0,0,8'h00,0,0,0, 0,1,0, 0,8'h00,0, "fill_full"));
        tv.push_back(mk(1,0,1,8'hEE,1,0,0, 0,1,0, 0,8'h00,0, "full_reject"));
        tv.push_back(mk(1,0,0,8'h00,0,0,1, 0,1,0, 1,8'h10,1, "first_rd"));
        for (int i = 0; i < 10; i++)
            tv.push_back(mk(1,0,1,8'(8'h14 + i),1,0,1, 1,1,0, 1,8'(8'h11 + i),1, "wrap_rw"));
        tv.push_back(mk(1,0,0,8'h00,0,0,1, 1,1,0, 1,8'h1B,1, "drain1"));
        tv.push_back(mk(1,0,0,8'h00,0,0,1, 1,1,0, 1,8'h1C,1, "drain2"));
        tv.push_back(mk(1,0,0,8'h00,0,0,1, 1,0,0, 1,8'h1D,1, "drain3"));

        foreach (tv[k]) apply(tv[k]);
        idle_inputs();

        check("scoreboard empty", 32'(sb.size()), 32'd0);

`ifdef ACL_FIFO_STATS_EN
        exp_pkt_a  = 3;
        exp_drop_a = 1;
        exp_pkt_b  = 14;
`else
        exp_pkt_a  = 0;
        exp_drop_a = 0;
        exp_pkt_b  = 0;
`endif
        check("a pkt_cnt",  32'(ifa.o_pkt_cnt),  32'(exp_pkt_a));
        check("a drop_cnt", 32'(ifa.o_drop_cnt), 32'(exp_drop_a));
        check("b pkt_cnt",  32'(ifb.o_pkt_cnt),  32'(exp_pkt_b));
        check("b drop_cnt", 32'(ifb.o_drop_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
